// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// A Start pulse in IDLE or DONE loads the operands and the carry-in. The
// adder then processes one bit per clock, LSB first, for WIDTH clocks. The
// sum, carry-out and signed overflow are registered on the edge that
// processes the MSB, and Done strobes for one cycle after that edge.
//
// Ports:
//   i_clock     rising-edge clock
//   i_reset_n   asynchronous active-low reset
//   i_start     start request, honoured only in IDLE or DONE
//   i_a, i_b    operands, sampled in the Start-accept cycle
//   i_cin       carry-in, sampled in the Start-accept cycle
//   o_busy      high while bits are being processed
//   o_done      one-cycle completion strobe
//   o_sum       registered sum, held until the next completion
//   o_cout      registered carry out of the MSB
//   o_overflow  registered signed overflow (carry into MSB ^ carry out)
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_co;
    logic             w_load;
    logic             w_last;

    // One-bit full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Full-adder cell on the current LSBs and carry, plus next-state decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        {w_co, w_s}  = full_add(r_a_sr[0], r_b_sr[0], r_c);
        w_last       = (r_cnt == LAST_CNT);
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Start is deliberately ignored here: no queueing, no resample.
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register with registered Busy/Done decoded from the next state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_SHIFT);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Operand/result shift registers, carry, bit counter and result capture.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_r_sr <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load) begin
            r_a_sr <= i_a;
            r_b_sr <= i_b;
            r_c    <= i_cin;
            r_cnt  <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_r_sr <= {w_s, r_r_sr[WIDTH-1:1]};
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_c    <= w_co;
            r_cnt  <= r_cnt + CW'(1);
            // On the MSB edge r_c is the carry into the MSB, so the
            // overflow is that carry XOR the carry out of the MSB.
            if (w_last) begin
                r_sum  <= {w_s, r_r_sr[WIDTH-1:1]};
                r_cout <= w_co;
                r_ovf  <= r_c ^ w_co;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
module tb_serial_adder;

    typedef struct {
        logic [32:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q8[$];
    exp_t        q16[$];
    int          run8 = 0;
    int          run16 = 0;

    logic        s_start8 = 1'b0;
    logic [7:0]  s_a8 = 8'h00;
    logic [7:0]  s_b8 = 8'h00;
    logic        s_cin8 = 1'b0;
    logic        d_busy8, d_done8, d_cout8, d_ovf8;
    logic [7:0]  d_sum8;

    logic        s_start16 = 1'b0;
    logic [15:0] s_a16 = 16'h0000;
    logic [15:0] s_b16 = 16'h0000;
    logic        s_cin16 = 1'b0;
    logic        d_busy16, d_done16, d_cout16, d_ovf16;
    logic [15:0] d_sum16;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start8),
        .i_a(s_a8), .i_b(s_b8), .i_cin(s_cin8),
        .o_busy(d_busy8), .o_done(d_done8), .o_sum(d_sum8),
        .o_cout(d_cout8), .o_overflow(d_ovf8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start16),
        .i_a(s_a16), .i_b(s_b16), .i_cin(s_cin16),
        .o_busy(d_busy16), .o_done(d_done16), .o_sum(d_sum16),
        .o_cout(d_cout16), .o_overflow(d_ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 1ms", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one Start cycle on the 8-bit DUT at the current negedge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [8:0] er, input logic eo);
        exp_t e;
        s_a8 = a; s_b8 = b; s_cin8 = cin; s_start8 = 1'b1;
        e.res = {24'd0, er}; e.ovf = eo; e.due = cyc + 9;
        q8.push_back(e);
        @(negedge clk);
        s_start8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t e;
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        s_a16 = a; s_b16 = b; s_cin16 = cin; s_start16 = 1'b1;
        e.res = {16'd0, r}; e.ovf = (a[15] == b[15]) && (r[15] != a[15]); e.due = cyc + 17;
        q16.push_back(e);
        @(negedge clk);
        s_start16 = 1'b0;
    endtask

    task automatic wait_done8();
        for (int k = 0; k < 40 && !d_done8; k++) @(negedge clk);
        check("done8_seen", {32'd0, d_done8}, 33'd1);
    endtask

    task automatic wait_done16();
        for (int k = 0; k < 60 && !d_done16; k++) @(negedge clk);
        check("done16_seen", {32'd0, d_done16}, 33'd1);
    endtask

    // Scoreboard monitor for the 8-bit DUT.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run8 = 0;
        end else begin
            if (d_done8) begin
                check("busy_done_excl8", {32'd0, d_busy8}, 33'd0);
                check("done8_expected", {32'd0, q8.size() != 0}, 33'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("result8", {24'd0, d_cout8, d_sum8}, e.res);
                    check("ovf8", {32'd0, d_ovf8}, {32'd0, e.ovf});
                    check("latency8", 33'(cyc), 33'(e.due));
                end
            end
            if (d_busy8) run8++;
            else if (run8 != 0) begin
                check("busy_len8", 33'(run8), 33'd8);
                run8 = 0;
            end
        end
    end

    // Scoreboard monitor for the 16-bit DUT.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run16 = 0;
        end else begin
            if (d_done16) begin
                check("busy_done_excl16", {32'd0, d_busy16}, 33'd0);
                check("done16_expected", {32'd0, q16.size() != 0}, 33'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("result16", {16'd0, d_cout16, d_sum16}, e.res);
                    check("ovf16", {32'd0, d_ovf16}, {32'd0, e.ovf});
                    check("latency16", 33'(cyc), 33'(e.due));
                end
            end
            if (d_busy16) run16++;
            else if (run16 != 0) begin
                check("busy_len16", 33'(run16), 33'd16);
                run16 = 0;
            end
        end
    end

    initial begin
        int dc;
        logic [7:0] a, b;
        logic       c;
        logic [8:0] r;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", {32'd0, d_busy8}, 33'd0);
        check("rst_done", {32'd0, d_done8}, 33'd0);
        check("rst_sum", {25'd0, d_sum8}, 33'd0);
        check("rst_cout", {32'd0, d_cout8}, 33'd0);
        check("rst_ovf", {32'd0, d_ovf8}, 33'd0);
        #19 rst_n = 1'b1;
        @(negedge clk);

        // Basic addition with signed overflow
        issue8(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
        wait_done8();
        // Carry out without overflow, then back-to-back with Cin
        issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        wait_done8();
        issue8(8'h80, 8'h80, 1'b1, 9'h101, 1'b1);
        wait_done8();
        @(negedge clk);

        // Start pulses during SHIFT are ignored
        issue8(8'h11, 8'h22, 1'b0, 9'h033, 1'b0);
        @(negedge clk);
        s_a8 = 8'hFF; s_b8 = 8'hFF; s_start8 = 1'b1;
        @(negedge clk); s_start8 = 1'b0;
        @(negedge clk);
        s_start8 = 1'b1;
        @(negedge clk); s_start8 = 1'b0;
        wait_done8();
        dc = 0;
        repeat (12) begin @(negedge clk); dc += int'(d_done8); end
        check("single_done_after_ignored", 33'(dc), 33'd0);

        // Start held high with operands changing every cycle
        s_start8 = 1'b1;
        for (int k = 0; k < 27; k++) begin
            exp_t e;
            a = 8'(k * 29 + 5); b = 8'(k * 55); c = k[0];
            s_a8 = a; s_b8 = b; s_cin8 = c;
            if (k % 9 == 0) begin
                r = {1'b0, a} + {1'b0, b} + {8'd0, c};
                e.res = {24'd0, r}; e.ovf = (a[7] == b[7]) && (r[7] != a[7]); e.due = cyc + 9;
                q8.push_back(e);
            end
            @(negedge clk);
        end
        s_start8 = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-operation
        issue8(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
        wait_done8();
        @(negedge clk);
        issue8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
        repeat (2) @(negedge clk);
        check("prior_sum_held", {25'd0, d_sum8}, 33'h096);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort_sum", {25'd0, d_sum8}, 33'd0);
        check("abort_cout", {32'd0, d_cout8}, 33'd0);
        check("abort_ovf", {32'd0, d_ovf8}, 33'd0);
        check("abort_busy", {32'd0, d_busy8}, 33'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        dc = 0;
        repeat (12) begin @(negedge clk); dc += int'(d_done8); end
        check("no_done_after_abort", 33'(dc), 33'd0);
        issue8(8'h01, 8'h02, 1'b1, 9'h004, 1'b0);
        wait_done8();
        @(negedge clk);

        // Random vectors with random gaps on both widths
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] ra, rb;
                    logic       rc;
                    logic [8:0] rr;
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    rr = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
                    issue8(ra, rb, rc, rr, (ra[7] == rb[7]) && (rr[7] != ra[7]));
                    wait_done8();
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 1000; i++) begin
                    issue16(16'($urandom), 16'($urandom), 1'($urandom));
                    wait_done16();
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        for (int k = 0; k < 100 && (q8.size() + q16.size()) != 0; k++) @(negedge clk);
        check("scoreboard_drained", 33'(q8.size() + q16.size()), 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
